// File: rtl/mul_seq_32bit_pkg.sv
// Shared types for the sequential 32-bit multiplier: data width, operation codes and FSM states.
package mul_seq_32bit_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/mul_seq_32bit_adder_64bit.sv
// 64-bit modulo-2^64 adder used for the shift-add accumulate step.
module adder_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mul_seq_32bit.sv
// Radix-2 shift-add multiplier (MUL/MULH/MULHSU/MULHU) with fixed 34-cycle latency.
// Define MUL_EARLY_EXIT_EN to leave CALC as soon as the remaining multiplier is zero.
module mul_seq_32bit
  import mul_seq_32bit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mul_state_e          state, state_nxt;
  mul_op_e             op_in, op_q;
  logic [2*XLEN-1:0]   mcand, acc, sum, prod;
  logic [XLEN-1:0]     mplier, mag_a, mag_b;
  logic [5:0]          cnt;
  logic                neg_in, neg_q;
  logic                a_signed, b_signed;
  logic                calc_exit;

  assign op_in    = mul_op_e'(op);
  assign a_signed = (op_in == MULH) || (op_in == MULHSU);
  assign b_signed = (op_in == MULH);
  // 0x80000000 negates to itself, which is already the correct unsigned magnitude
  assign mag_a    = (a_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
  assign mag_b    = (b_signed && b[XLEN-1]) ? (~b + 1'b1) : b;
  assign neg_in   = (a_signed & a[XLEN-1]) ^ (b_signed & b[XLEN-1]);

  adder_64bit u_adder (
    .a   (acc),
    .b   (mcand),
    .sum (sum)
  );

`ifdef MUL_EARLY_EXIT_EN
  assign calc_exit = (mplier == '0) || (cnt == 6'd32);
`else
  assign calc_exit = (cnt == 6'd31);
`endif

  assign prod  = neg_q ? (~acc + 1'b1) : acc;
  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (calc_exit) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      op_q   <= MUL;
      neg_q  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{XLEN{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            op_q   <= op_in;
            neg_q  <= neg_in;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
        end
        FIX: begin
          result <= (op_q == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_32bit.sv
// Directed self-checking bench for mul_seq_32bit: results, latency, overlap and reset abort.
module tb_mul_seq_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        ready, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  mul_seq_32bit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected done cycle offset from the accept cycle
  function automatic int lat_of(input logic [1:0] o, input logic [31:0] y);
`ifdef MUL_EARLY_EXIT_EN
    logic [31:0] mag;
    int k;
    mag = (o == 2'd1 && y[31]) ? (~y + 32'd1) : y;
    k = 0;
    for (int j = 0; j < 32; j++) if (mag[j]) k = j + 1;
    return 3 + k;
`else
    return 34;
`endif
  endfunction

  // Accept one operation, optionally injecting a start (9x9) or rst at offset intr_at
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp_res,
                     input int intr_at, input bit intr_rst);
    int lat;
    int ndone;
    logic [31:0] res_at_done;
    @(negedge clk);
    chk({tag, "_ready_idle"}, {31'd0, ready}, 32'd1);
    start = 1'b1; op = o; a = x; b = y;
    lat = -1; ndone = 0; res_at_done = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          res_at_done = result;
        end
      end
      if (i == 1) chk({tag, "_ready_busy"}, {31'd0, ready}, 32'd0);
      if (intr_rst && i == intr_at + 1) begin
        chk({tag, "_ready_after_rst"}, {31'd0, ready}, 32'd1);
        chk({tag, "_result_after_rst"}, result, 32'd0);
      end
      start = 1'b0; rst = 1'b0;
      a = $urandom(); b = $urandom(); op = 2'($urandom());
      if (i == intr_at) begin
        if (intr_rst) rst = 1'b1;
        else begin
          start = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9;
        end
      end
    end
    if (intr_rst) begin
      chk({tag, "_done_count"}, 32'(ndone), 32'd0);
      chk({tag, "_result_held"}, result, 32'd0);
    end else begin
      chk({tag, "_result"}, res_at_done, exp_res);
      chk({tag, "_latency"}, 32'(lat), 32'(lat_of(o, y)));
      chk({tag, "_done_count"}, 32'(ndone), 32'd1);
      chk({tag, "_result_held"}, result, exp_res);
    end
    chk({tag, "_ready_end"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; op = 2'd0; a = 32'd1; b = 32'd1;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0; start = 1'b0;

    run("mul_7x6",          2'd0, 32'd7,        32'd6,        32'h0000002A, 0, 1'b0);
    run("mulh_m1xm1",       2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 1'b0);
    run("mulhu_max",        2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1'b0);
    run("mulhsu_m1x2",      2'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 0, 1'b0);
    run("mulh_min_sq",      2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 0, 1'b0);
    run("mulh_min_x1",      2'd1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 0, 1'b0);
    run("mulhsu_min_xmax",  2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1'b0);
    run("mul_max_sq_lo",    2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 1'b0);
    run("mul_x0",           2'd0, 32'h12345678, 32'h00000000, 32'h00000000, 0, 1'b0);
    run("mul_x1",           2'd0, 32'h12345678, 32'h00000001, 32'h12345678, 0, 1'b0);
    run("mul_3x5_ignore",   2'd0, 32'd3,        32'd5,        32'h0000000F, 10, 1'b0);
    run("mul_abort",        2'd0, 32'd3,        32'd5,        32'h00000000, 20, 1'b1);
    run("mul_2x2",          2'd0, 32'd2,        32'd2,        32'h00000004, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
